// File: rtl/uart_msg_tx_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_msg_tx_arbiter_pkg                                       |
// | Purpose  : Shared UART message definitions: message width, header and    |
// |            payload field ranges, header codes, message type and the      |
// |            TX arbiter state encoding.                                    |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package uart_msg_tx_arbiter_pkg;

  localparam int UART_MSG_WIDTH = 64;

  // Header occupies the top byte, payload the remaining bits.
  localparam int HDR_MSB     = UART_MSG_WIDTH - 1;
  localparam int HDR_LSB     = UART_MSG_WIDTH - 8;
  localparam int PAYLOAD_MSB = HDR_LSB - 1;
  localparam int PAYLOAD_LSB = 0;

  typedef logic [UART_MSG_WIDTH-1:0] uart_msg_t;

  typedef enum logic [7:0] {
    SYS_STATUS         = 8'h01,
    MEM_PARAMS         = 8'h02,
    MOD_PARAMS         = 8'h03,
    DEMOD_PARAMS       = 8'h04,
    REPLACE_NUM        = 8'h05,
    RECEIVED_WRONG_NUM = 8'h06
  } uart_msg_hdr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } tx_arb_state_t;

  function automatic logic [7:0] msg_header(input uart_msg_t msg);
    return msg[HDR_MSB:HDR_LSB];
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_msg_tx_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_msg_tx_arbiter_if                                        |
// | Purpose  : Requester and UART TX byte handshake bundle of the message    |
// |            arbiter.                                                      |
// | Ports    : master - arbiter side (drives req_ready, tx_*, busy, grant_id) |
// |            slave  - environment side (drives req_valid, req_msg,         |
// |                     tx_ready)                                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface uart_msg_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int MSG_WIDTH  = 64,
  parameter int DATA_WIDTH = 8
);
  localparam int GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*MSG_WIDTH-1:0] req_msg;
  logic [DATA_WIDTH-1:0]        tx_data;
  logic                         tx_valid;
  logic                         tx_ready;
  logic                         busy;
  logic [GRANT_W-1:0]           grant_id;

  modport master (
    input  req_valid, req_msg, tx_ready,
    output req_ready, tx_data, tx_valid, busy, grant_id
  );

  modport slave (
    output req_valid, req_msg, tx_ready,
    input  req_ready, tx_data, tx_valid, busy, grant_id
  );
endinterface
`default_nettype wire

// File: rtl/uart_msg_tx_arbiter_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_arbiter                                                    |
// | Purpose  : Combinational round-robin pick: first asserted request found   |
// |            searching from ptr upwards, wrapping modulo NUM_REQ.          |
// | Ports    : req   in  request vector                                      |
// |            ptr   in  search start index                                  |
// |            grant out one-hot winner (zero when no request)               |
// |            idx   out winner index                                        |
// |            any   out at least one request present                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int cand;
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_msg_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_msg_tx_arbiter                                           |
// | Purpose  : Round-robin share of the host UART transmitter between        |
// |            message sources. Latches one message per grant and sends it   |
// |            LSB word first over the tx valid/ready byte interface.        |
// | Ports    : clk      in  system clock                                     |
// |            n_reset  in  asynchronous active-low reset                    |
// |            bus      master modport: req_valid/req_ready/req_msg,         |
// |                     tx_data/tx_valid/tx_ready, busy, grant_id            |
// | Options  : UART_TX_ARB_GAP_EN - insert GAP_CYCLES idle clocks after each |
// |            message before the next grant                                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_msg_tx_arbiter
  import uart_msg_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int MSG_WIDTH  = UART_MSG_WIDTH,
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  n_reset,
  uart_msg_tx_arbiter_if.master bus
);

  localparam int c_words = MSG_WIDTH / DATA_WIDTH;
  localparam int c_cnt_w = (c_words > 1) ? $clog2(c_words) : 1;
  localparam int c_gnt_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (MSG_WIDTH % DATA_WIDTH != 0) begin : g_width_check
    $error("MSG_WIDTH must be a multiple of DATA_WIDTH");
  end
  if (GAP_CYCLES < 0) begin : g_gap_check
    $error("GAP_CYCLES must not be negative");
  end

  tx_arb_state_t          r_state;
  tx_arb_state_t          w_state_nxt;
  logic [MSG_WIDTH-1:0]   r_shift;
  logic [c_cnt_w-1:0]     r_byte_cnt;
  logic [c_gnt_w-1:0]     r_ptr;
  logic [c_gnt_w-1:0]     r_grant_id;
  logic [NUM_REQ-1:0]     w_grant;
  logic [c_gnt_w-1:0]     w_idx;
  logic                   w_any;
  logic                   w_accept;
  logic                   w_tx_hs;
  logic                   w_last;
  logic [MSG_WIDTH-1:0]   w_sel_msg;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (c_gnt_w)
  ) u_rr_arbiter (
    .req   (bus.req_valid),
    .ptr   (r_ptr),
    .grant (w_grant),
    .idx   (w_idx),
    .any   (w_any)
  );

  assign w_accept  = (r_state == ST_IDLE) && w_any;
  assign w_tx_hs   = (r_state == ST_SEND) && bus.tx_ready;
  assign w_last    = (r_byte_cnt == c_cnt_w'(c_words - 1));
  assign w_sel_msg = bus.req_msg[int'(w_idx)*MSG_WIDTH +: MSG_WIDTH];

  // Ready is also held low while reset is asserted so nothing can appear
  // accepted by a producer during reset.
  assign bus.req_ready = (r_state == ST_IDLE && n_reset) ? w_grant : '0;
  assign bus.tx_valid  = (r_state == ST_SEND);
  assign bus.tx_data   = r_shift[DATA_WIDTH-1:0];
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.grant_id  = r_grant_id;

`ifdef UART_TX_ARB_GAP_EN
  localparam int c_gap_w = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [c_gap_w-1:0] r_gap_cnt;
  logic               w_gap_done;

  assign w_gap_done = (r_gap_cnt == c_gap_w'(GAP_CYCLES - 1));

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)
      r_gap_cnt <= '0;
    else if (r_state == ST_GAP)
      r_gap_cnt <= r_gap_cnt + c_gap_w'(1);
    else
      r_gap_cnt <= '0;
  end
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_SEND;
      ST_SEND: begin
        if (w_tx_hs && w_last) begin
`ifdef UART_TX_ARB_GAP_EN
          w_state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
`else
          w_state_nxt = ST_IDLE;
`endif
        end
      end
      ST_GAP: begin
`ifdef UART_TX_ARB_GAP_EN
        if (w_gap_done) w_state_nxt = ST_IDLE;
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_shift    <= '0;
      r_byte_cnt <= '0;
      r_ptr      <= '0;
      r_grant_id <= '0;
    end else if (w_accept) begin
      r_shift    <= w_sel_msg;
      r_grant_id <= w_idx;
      r_byte_cnt <= '0;
      r_ptr      <= (w_idx == c_gnt_w'(NUM_REQ - 1)) ? '0 : w_idx + c_gnt_w'(1);
    end else if (w_tx_hs) begin
      r_shift    <= r_shift >> DATA_WIDTH;
      r_byte_cnt <= w_last ? '0 : r_byte_cnt + c_cnt_w'(1);
    end
  end

endmodule
`default_nettype wire
